// File: rtl/byte_parity_pkg.sv
// Shared types, widths and the masked-parity helper for the byte parity scheduler.
package byte_parity_pkg;
  localparam int DATA_W  = 8;
  localparam int DP_W    = 9;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [DP_W-1:0] dp;
    logic            id;
    logic            last;
    logic            frame_par;
    logic            trunc;
  } out_beat_t;

  function automatic logic masked_par(input logic [DATA_W-1:0] d,
                                      input logic [DATA_W-1:0] en);
    return ^(d & en);
  endfunction
endpackage

// File: rtl/byte_parity_sched_if.sv
// Two-requester beat bus plus the single result stream of the parity scheduler.
interface byte_parity_sched_if;
  import byte_parity_pkg::*;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_last;
  logic              req0_ready;
  logic [DATA_W-1:0] en0_mask;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_last;
  logic              req1_ready;
  logic [DATA_W-1:0] en1_mask;

  logic              out_valid;
  logic              out_ready;
  logic [DP_W-1:0]   out_dp;
  logic              out_id;
  logic              out_last;
  logic              out_frame_par;
  logic              out_trunc;

  modport master (
    output req0_valid, req0_data, req0_last, en0_mask,
    output req1_valid, req1_data, req1_last, en1_mask,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_dp, out_id, out_last, out_frame_par, out_trunc
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, en0_mask,
    input  req1_valid, req1_data, req1_last, en1_mask,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_dp, out_id, out_last, out_frame_par, out_trunc
  );
endinterface

// File: rtl/byte_mask_parity.sv
// Combinational masked byte parity: p = XOR of d[i] & en[i].
module byte_mask_parity
  import byte_parity_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] en,
  output logic              p
);
  assign p = masked_par(d, en);
endmodule

// File: rtl/byte_parity_sched.sv
// Frame-granular round-robin scheduler of two byte streams into one output
// register stage, tagging each beat with masked parity and frame parity.
module byte_parity_sched
  import byte_parity_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input logic               clk,
  input logic               rst,
  byte_parity_sched_if.slave bus
);

  logic [NUM_REQ-1:0]             valid, last, ready, par;
  logic [NUM_REQ-1:0][DATA_W-1:0] data, mask_in;

  assign valid   = {bus.req1_valid, bus.req0_valid};
  assign last    = {bus.req1_last,  bus.req0_last};
  assign data    = {bus.req1_data,  bus.req0_data};
  assign mask_in = {bus.en1_mask,   bus.en0_mask};
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovld_q, ovld_d;
  out_beat_t         ob_q, ob_d;

  // Per-requester parity against the mask captured at grant; only the
  // granted lane's result is ever consumed.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_par
    byte_mask_parity u_par (
      .d  (data[g]),
      .en (mask_q),
      .p  (par[g])
    );
  end

  logic slot_free, take, beat_par, at_max, trunc, fin;

  assign slot_free = bus.out_ready | ~ovld_q;
  assign beat_par  = par[gnt_q];
  assign at_max    = (cnt_q == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ob_d    = ob_q;
    ovld_d  = ovld_q & ~bus.out_ready;
    ready   = '0;
    take    = 1'b0;
    trunc   = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant cycle never carries a beat; the pointer breaks ties only.
        if (|valid) begin
          gnt_d   = (&valid) ? ptr_q : valid[1];
          mask_d  = mask_in[gnt_d];
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        ready[gnt_q] = slot_free;
        take         = valid[gnt_q] & slot_free;
        if (take) begin
          trunc  = at_max & ~last[gnt_q];
          fin    = last[gnt_q] | trunc;
          acc_d  = acc_q ^ beat_par;
          cnt_d  = cnt_q + CNT_W'(1);
          ovld_d = 1'b1;
          ob_d   = '{dp:        {beat_par, data[gnt_q]},
                     id:        gnt_q,
                     last:      fin,
                     frame_par: acc_q ^ beat_par,
                     trunc:     trunc};
          if (fin) begin
            state_d = IDLE;
            ptr_d   = ~gnt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      mask_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
      ob_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
      ob_q    <= ob_d;
    end
  end

  assign bus.out_valid     = ovld_q;
  assign bus.out_dp        = ob_q.dp;
  assign bus.out_id        = ob_q.id;
  assign bus.out_last      = ob_q.last;
  assign bus.out_frame_par = ob_q.frame_par;
  assign bus.out_trunc     = ob_q.trunc;

endmodule

// File: tb/tb_byte_parity_sched.sv
// Directed scoreboard bench: drivers queue hand-computed beats, a negedge monitor pops and compares.
module tb_byte_parity_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_parity_sched_if bus();

  byte_parity_sched #(.MAX_BEATS(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [8:0] dp;
    logic       id;
    logic       last;
    logic       fp;
    logic       trunc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  logic        hold_q = 1'b0;
  logic [12:0] hold_snap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [8:0] dp, input logic id, input logic last,
                             input logic fp, input logic trunc);
    exp_t e;
    e = '{dp: dp, id: id, last: last, fp: fp, trunc: trunc};
    sbq.push_back(e);
  endtask

  task automatic beat(input int r, input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    if (r == 0) begin bus.req0_valid = 1; bus.req0_data = d; bus.req0_last = l; end
    else        begin bus.req1_valid = 1; bus.req1_data = d; bus.req1_last = l; end
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if ((r == 0) ? bus.req0_ready : bus.req1_ready) ok = 1;
    end
    @(posedge clk); #1;
    if (r == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL beat_timeout r%0d data %0h: got no ready, expected accept", r, d);
    end
  endtask

  function automatic logic [12:0] cur_out();
    return {bus.out_valid, bus.out_dp, bus.out_id, bus.out_last, bus.out_trunc, bus.out_frame_par};
  endfunction

  // Monitor: scoreboard pop on each output transfer, hold stability, ready exclusivity.
  always @(negedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) chk("hold_stable", 32'(cur_out()), 32'(hold_snap));
      if (bus.req0_ready | bus.req1_ready)
        chk("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_beat: got dp %0h id %0d, expected none", bus.out_dp, bus.out_id);
        end else begin
          mon_e = sbq.pop_front();
          chk($sformatf("beat id%0d dp%0h {dp,id,last,trunc,fp}", mon_e.id, mon_e.dp),
              32'({bus.out_dp, bus.out_id, bus.out_last, bus.out_trunc,
                   mon_e.last ? bus.out_frame_par : 1'b0}),
              32'({mon_e.dp, mon_e.id, mon_e.last, mon_e.trunc,
                   mon_e.last ? mon_e.fp : 1'b0}));
        end
      end
      hold_q    <= bus.out_valid & ~bus.out_ready;
      hold_snap <= cur_out();
    end
  end

  initial begin
    bus.req0_valid = 0; bus.req0_data = '0; bus.req0_last = 0; bus.en0_mask = '0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.req1_last = 0; bus.en1_mask = '0;
    bus.out_ready  = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(cur_out()), 32'd0);
    chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(posedge clk); #1;

    // Single beat on req0
    bus.en0_mask = 8'hFF;
    expect_beat(9'h0A5, 0, 1, 0, 0);
    beat(0, 8'hA5, 1);

    // Mask selection on req1
    bus.en1_mask = 8'h01;
    expect_beat(9'h1FF, 1, 1, 1, 0);
    beat(1, 8'hFF, 1);
    bus.en1_mask = 8'h03;
    expect_beat(9'h0FF, 1, 1, 0, 0);
    beat(1, 8'hFF, 1);

    // Mask change mid-frame ignored until next grant
    expect_beat(9'h003, 1, 0, 0, 0);
    expect_beat(9'h004, 1, 1, 0, 0);
    beat(1, 8'h03, 0);
    bus.en1_mask = 8'hFF;
    beat(1, 8'h04, 1);

    // Round robin with both requesters pending
    bus.en0_mask = 8'hFF; bus.en1_mask = 8'hFF;
    expect_beat(9'h110, 0, 0, 1, 0); expect_beat(9'h011, 0, 1, 1, 0);
    expect_beat(9'h120, 1, 0, 1, 0); expect_beat(9'h021, 1, 1, 1, 0);
    expect_beat(9'h012, 0, 0, 0, 0); expect_beat(9'h113, 0, 1, 1, 0);
    expect_beat(9'h022, 1, 0, 0, 0); expect_beat(9'h123, 1, 1, 1, 0);
    fork
      begin beat(0, 8'h10, 0); beat(0, 8'h11, 1); beat(0, 8'h12, 0); beat(0, 8'h13, 1); end
      begin beat(1, 8'h20, 0); beat(1, 8'h21, 1); beat(1, 8'h22, 0); beat(1, 8'h23, 1); end
    join

    // Backpressure mid-frame
    expect_beat(9'h101, 0, 0, 1, 0);
    expect_beat(9'h003, 0, 0, 1, 0);
    expect_beat(9'h107, 0, 1, 0, 0);
    fork
      begin beat(0, 8'h01, 0); beat(0, 8'h03, 0); beat(0, 8'h07, 1); end
      begin
        repeat (3) @(posedge clk); #1 bus.out_ready = 0;
        repeat (4) @(posedge clk); #1 bus.out_ready = 1;
      end
    join

    // Truncation at 16 beats, then a fresh frame with no dropped beats
    for (int k = 1; k <= 16; k++)
      expect_beat(9'h101, 0, (k == 16), k[0], (k == 16));
    expect_beat(9'h101, 0, 0, 1, 0);
    expect_beat(9'h101, 0, 1, 0, 0);
    for (int k = 1; k <= 17; k++) beat(0, 8'h01, 0);
    beat(0, 8'h01, 1);

    // Reset during beat 2 of a 4-beat frame
    expect_beat(9'h101, 0, 0, 1, 0);
    beat(0, 8'h01, 0);
    beat(0, 8'h02, 0);
    bus.req0_valid = 1; bus.req0_data = 8'h03; bus.req0_last = 0;
    #2 rst = 1;
    #1;
    chk("midrst_out", 32'(cur_out()), 32'd0);
    chk("midrst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    bus.req0_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    expect_beat(9'h055, 0, 1, 0, 0);
    expect_beat(9'h00F, 1, 1, 0, 0);
    fork
      beat(0, 8'h55, 1);
      beat(1, 8'h0F, 1);
    join

    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
